// File: rtl/complex_row_accum_scheduler.sv
// Row accumulation scheduler: streams a row of chunks from memory into an
// external adder-tree datapath and returns the accumulated sum per command.
module complex_row_accum_scheduler #(
  parameter int element_width = 64,
  parameter int NI            = 8,
  parameter int AW            = 10,
  parameter int CW            = 8,
  parameter int LAT           = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [AW-1:0]               cmd_base,
  input  logic [CW-1:0]               cmd_chunks,
  output logic                        mem_rd_en,
  output logic [AW-1:0]               mem_addr,
  input  logic [NI*element_width-1:0] mem_rd_data,
  output logic [NI*element_width-1:0] dp_row_input,
  output logic                        dp_valid_in,
  output logic                        dp_start,
  input  logic [element_width-1:0]    dp_sum,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [element_width-1:0]    res_data,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                     state_q;
  logic [CW-1:0]              k_q;
  logic [CW-1:0]              chunks_q;
  logic [AW-1:0]              base_q;
  logic [AW-1:0]              mem_addr_q;
  logic                       mem_rd_en_q;
  logic                       dp_valid_q;
  logic                       dp_last_q;
  logic                       dp_start_q;
  logic                       res_valid_q;
  logic [element_width-1:0]   res_data_q;
  logic                       busy_q;
  logic [LAT-1:0]             sr_valid_q;
  logic [LAT-1:0]             sr_last_q;
  logic                       rd_last_s;
  logic                       tag_out_s;

  // k indexes the read currently on the memory bus, so equality marks the final chunk
  assign rd_last_s = (state_q == ISSUE) && (k_q == (chunks_q - CW'(1)));
  assign tag_out_s = sr_valid_q[LAT-1] & sr_last_q[LAT-1];

  assign cmd_ready    = ~busy_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_addr     = mem_addr_q;
  assign dp_row_input = mem_rd_data;
  assign dp_valid_in  = dp_valid_q;
  assign dp_start     = dp_start_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign busy         = busy_q;

  // Control FSM with registered memory, datapath-enable and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      chunks_q    <= '0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      dp_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            busy_q <= 1'b1;
            if (cmd_chunks == '0) begin
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              state_q     <= HOLD;
            end else begin
              base_q      <= cmd_base;
              chunks_q    <= cmd_chunks;
              k_q         <= '0;
              mem_addr_q  <= cmd_base;
              mem_rd_en_q <= 1'b1;
              dp_start_q  <= 1'b1;
              state_q     <= ISSUE;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (rd_last_s) begin
            mem_rd_en_q <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            k_q        <= k_q + CW'(1);
            mem_addr_q <= base_q + AW'(k_q + CW'(1));
          end
        end
        DRAIN: begin
          if (tag_out_s) begin
            res_data_q  <= dp_sum;
            res_valid_q <= 1'b1;
            dp_start_q  <= 1'b0;
            state_q     <= HOLD;
          end else begin
            state_q <= DRAIN;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_rd_en_q <= 1'b0;
          dp_start_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Valid/last tags follow each chunk through the datapath latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_last_q  <= 1'b0;
      sr_valid_q <= '0;
      sr_last_q  <= '0;
    end else begin
      dp_valid_q <= mem_rd_en_q;
      dp_last_q  <= rd_last_s;
      sr_valid_q <= (sr_valid_q << 1) | LAT'(dp_valid_q);
      sr_last_q  <= (sr_last_q << 1) | LAT'(dp_last_q);
    end
  end

endmodule

// File: tb/tb_complex_row_accum_scheduler.sv
// Bench for complex_row_accum_scheduler: random chunk memory, an accumulating
// datapath stand-in, and a row-sum reference computed straight from memory.
module tb_complex_row_accum_scheduler;
  localparam int EW  = 64;
  localparam int NI  = 8;
  localparam int AW  = 10;
  localparam int CW  = 8;
  localparam int LAT = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [AW-1:0]    cmd_base;
  logic [CW-1:0]    cmd_chunks;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [NI*EW-1:0] mem_rd_data;
  logic [NI*EW-1:0] dp_row_input;
  logic             dp_valid_in, dp_start;
  logic [EW-1:0]    dp_sum;
  logic             res_valid, res_ready;
  logic [EW-1:0]    res_data;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit tie   = 1'b0;

  logic [NI*EW-1:0] memarr [1024];
  logic [EW-1:0]    acc, acc_next;
  logic [EW-1:0]    hist [LAT];

  complex_row_accum_scheduler #(
    .element_width(EW), .NI(NI), .AW(AW), .CW(CW), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_chunks(cmd_chunks),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .dp_row_input(dp_row_input), .dp_valid_in(dp_valid_in), .dp_start(dp_start), .dp_sum(dp_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory returns data one cycle after the read strobe
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= memarr[mem_addr];

  function automatic logic [EW-1:0] add_chunk(input logic [EW-1:0] a, input logic [NI*EW-1:0] row);
    logic [31:0] re, im;
    re = a[63:32];
    im = a[31:0];
    for (int e = 0; e < NI; e++) begin
      re = re + row[e*EW+32 +: 32];
      im = im + row[e*EW +: 32];
    end
    return {re, im};
  endfunction

  // datapath stand-in: accumulator cleared by dp_start low, result delayed to meet LAT
  always_comb begin
    acc_next = acc;
    if (!dp_start) acc_next = '0;
    else if (dp_valid_in) acc_next = add_chunk(acc, dp_row_input);
  end

  always @(posedge clk) begin
    acc <= acc_next;
    hist[0] <= acc_next;
    for (int j = 1; j < LAT; j++) hist[j] <= hist[j-1];
  end
  assign dp_sum = hist[LAT-1];

  function automatic logic [EW-1:0] ref_sum(input int base, input int n);
    int unsigned re, im;
    logic [EW-1:0] el;
    re = 0;
    im = 0;
    for (int i = 0; i < n; i++) begin
      for (int e = 0; e < NI; e++) begin
        el = memarr[(base + i) % 1024][e*EW +: EW];
        re = re + el[63:32];
        im = im + el[31:0];
      end
    end
    return {re[31:0], im[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".mem_rd_en"}, mem_rd_en, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".dp_valid_in"}, dp_valid_in, 0);
    chk({tag, ".dp_start"}, dp_start, 0);
    chk({tag, ".res_valid"}, res_valid, 0);
    chk({tag, ".res_data"}, res_data, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  task automatic do_row(input string tag, input int base, input int n, input int hold);
    int w, lat, nrd, first_rd, addr_err, start_err, stab_err, exp_lat;
    logic [EW-1:0] exp;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk({tag, ".ready"}, cmd_ready, 1);
    exp = ref_sum(base, n);
    exp_lat = (n == 0) ? 0 : 1 + n + LAT;
    cmd_valid = 1'b1; cmd_base = AW'(base); cmd_chunks = CW'(n);
    lat = -1; nrd = 0; first_rd = -1; addr_err = 0; start_err = 0;
    for (int off = 0; off < 600; off++) begin
      @(negedge clk);
      if (off == 0) begin
        cmd_valid = 1'b0; cmd_base = AW'($urandom); cmd_chunks = CW'($urandom);
        if (n > 0) chk({tag, ".busy"}, busy, 1);
      end
      if (mem_rd_en) begin
        if (first_rd < 0) first_rd = off;
        if (mem_addr !== AW'(base + nrd)) addr_err++;
        if (off != first_rd + nrd) addr_err++;
        nrd++;
      end
      if (res_valid) begin lat = off; break; end
      if (n > 0 && !dp_start) start_err++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".reads"}, nrd, n);
    if (n > 0) chk({tag, ".first_read"}, first_rd, 0);
    chk({tag, ".addr_err"}, addr_err, 0);
    chk({tag, ".start_gap"}, start_err, 0);
    chk({tag, ".res_data"}, res_data, exp);
    chk({tag, ".start_after"}, dp_start, 0);
    chk({tag, ".ready_hold"}, cmd_ready, 0);
    if (!tie) begin
      stab_err = 0;
      for (int h = 0; h < hold; h++) begin
        cmd_valid = 1'b1; cmd_base = AW'($urandom); cmd_chunks = CW'($urandom_range(1, 9));
        @(negedge clk);
        if (res_valid !== 1'b1 || res_data !== exp) stab_err++;
        if (cmd_ready !== 1'b0 || mem_rd_en !== 1'b0 || dp_start !== 1'b0) stab_err++;
      end
      cmd_valid = 1'b0;
      chk({tag, ".hold_stable"}, stab_err, 0);
      res_ready = 1'b1;
    end
    @(negedge clk);
    if (!tie) res_ready = 1'b0;
    chk({tag, ".valid_clear"}, res_valid, 0);
    chk({tag, ".ready_back"}, cmd_ready, 1);
    chk({tag, ".start_idle"}, dp_start, 0);
  endtask

  initial begin
    int cnt;
    for (int a = 0; a < 1024; a++)
      for (int e = 0; e < NI; e++) memarr[a][e*EW +: EW] = {$urandom, $urandom};
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; cmd_base = '0; cmd_chunks = '0;
    repeat (LAT + 3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready", cmd_ready, 1);

    do_row("single", 'h010, 3, 2);
    do_row("wrap", 'h3FE, 4, 0);
    do_row("zero", 0, 0, 1);
    do_row("backpressure", $urandom_range(0, 1023), 6, 20);

    // reset two cycles after the fifth of eight reads
    cmd_valid = 1'b1; cmd_base = AW'($urandom); cmd_chunks = CW'(8);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.ready", cmd_ready, 1);
    cnt = 0;
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      @(negedge clk);
      if (res_valid || mem_rd_en) cnt++;
    end
    chk("rst_mid.no_result", cnt, 0);
    do_row("post_rst", $urandom_range(0, 1023), 2, 0);

    for (int r = 0; r < 6; r++)
      do_row("random", $urandom_range(0, 1023), $urandom_range(1, 24), $urandom_range(0, 3));
    do_row("max_chunks", $urandom_range(0, 1023), 255, 1);

    tie = 1'b1;
    res_ready = 1'b1;
    do_row("b2b_first", $urandom_range(0, 1023), 2, 0);
    do_row("b2b_second", $urandom_range(0, 1023), 5, 0);
    res_ready = 1'b0;
    tie = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_row_accum_scheduler.md
COMPLEX_ROW_ACCUM_SCHEDULER -- requirements
Module: complex_row_accum_scheduler

Interface
REQ-001 The module SHALL have these parameters: element_width, default 64, width of one packed complex element; NI, default 8, elements per chunk; AW, default 10, chunk-memory address width; CW, default 8, chunk-count width; LAT, default 12, cycles from dp_valid_in high to the matching dp_sum valid.
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-003 The command ports SHALL be: cmd_valid in 1, request to accumulate one row; cmd_ready out 1, command accepted when high together with cmd_valid; cmd_base in AW, first chunk address; cmd_chunks in CW, number of chunks in the row.
REQ-004 The memory ports SHALL be: mem_rd_en out 1, chunk read strobe; mem_addr out AW, chunk address; mem_rd_data in NI*element_width, chunk data, valid exactly 1 cycle after mem_rd_en.
REQ-005 The datapath ports SHALL be: dp_row_input out NI*element_width, chunk driven into the adder tree; dp_valid_in out 1, chunk-valid strobe; dp_start out 1, accumulate enable, low clears the accumulator; dp_sum in element_width, accumulated sum.
REQ-006 The result ports SHALL be: res_valid out 1, result available; res_ready in 1, result consumed when high together with res_valid; res_data out element_width, row sum; busy out 1, high in any state other than IDLE.

Function
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and HOLD.
REQ-008 cmd_ready SHALL be 1 only in IDLE.
REQ-009 When a command is accepted with cmd_chunks greater than 0, the FSM SHALL latch cmd_base and cmd_chunks, clear the issue counter k, and go to ISSUE.
REQ-010 When a command is accepted with cmd_chunks equal to 0, the FSM SHALL go directly to HOLD with res_data equal to 0, and SHALL issue no reads.
REQ-011 In ISSUE, each cycle SHALL assert mem_rd_en with mem_addr = base+k modulo 2^AW, and SHALL increment k. The address SHALL wrap silently.
REQ-012 Reads SHALL be issued on consecutive cycles with no bubbles.
REQ-013 When k equals chunks-1 in ISSUE, that read SHALL be tagged last and the FSM SHALL go to DRAIN.
REQ-014 dp_row_input SHALL equal mem_rd_data combinationally, and dp_valid_in SHALL equal mem_rd_en delayed by one register.
REQ-015 dp_start SHALL be 1 from the cycle after command acceptance until the cycle of result capture inclusive, and 0 otherwise.
REQ-016 The module SHALL contain an internal LAT-stage shift register carrying (valid, last) from dp_valid_in.
REQ-017 When a (valid, last) pair with last=1 emerges from the shift register, the module SHALL capture dp_sum into res_data, set res_valid to 1, and go to HOLD.
REQ-018 In HOLD, res_valid and res_data SHALL be held stable until res_ready is high.
REQ-019 On the handshake cycle in HOLD, res_valid SHALL clear and the FSM SHALL return to IDLE, so cmd_ready rises the next cycle.
REQ-020 The total latency from acceptance with N chunks to res_valid SHALL be 1 + N + LAT cycles.
REQ-021 res_ready asserted while res_valid is 0 SHALL have no effect.
REQ-022 cmd_valid outside IDLE SHALL be ignored, and its inputs SHALL not be latched.
REQ-023 cmd_chunks equal to 2^CW-1 SHALL be supported without counter overflow, since k is CW bits and compared for equality.
REQ-024 The module SHALL perform no arithmetic on data; all summation is done by the datapath.

Reset
REQ-025 When rst is 1, asynchronously: the FSM SHALL go to IDLE, and k, the latched base and the latched chunks SHALL be 0.
REQ-026 When rst is 1, asynchronously, these outputs SHALL be 0: all shift-register stages, mem_rd_en, dp_valid_in, dp_start, res_valid, res_data and busy; mem_addr SHALL also be 0.
REQ-027 Reset asserted mid-ISSUE or mid-DRAIN SHALL abort the row with no result produced, and in-flight tags SHALL be discarded.
REQ-028 After rst deasserts, cmd_ready SHALL be 1 on the first clock edge.

Verification
REQ-029 Single row: base=0x010, chunks=3, LAT=12 -> mem_addr 0x010, 0x011, 0x012 on 3 consecutive cycles; res_valid at cycle 16 after acceptance with res_data equal to dp_sum at that cycle; dp_start low afterwards.
REQ-030 Wrap: base=0x3FE, chunks=4, AW=10 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001.
REQ-031 Zero chunks: chunks=0 -> no mem_rd_en; res_valid=1 and res_data=0 on the next cycle.
REQ-032 Backpressure: res_ready held 0 for 20 cycles -> res_valid and res_data stable throughout; cmd_ready=0 and a new cmd_valid is not accepted; after res_ready=1, IDLE on the next cycle.
REQ-033 Reset mid-op: rst pulsed 2 cycles after issuing chunk 5 of 8 -> all outputs 0 immediately; no res_valid ever appears for the aborted row; a new row of 2 chunks then completes at 1+2+LAT cycles.
REQ-034 Back-to-back: two rows of chunks 2 and 5 with res_ready tied to 1 -> dp_start drops for at least one cycle between rows; the two results are returned in order.
